// File: rtl/control_unit.sv
// control_unit: ID-stage instruction decode plus hazard control for data_path.
// A 4-bit opcode is decoded combinationally into the cu_* control word.
// A registered FSM and a shifting destination scoreboard replace the control
// word with a bubble on RAW hazards, during the branch resolve window and
// after HALT. They also drive stall/flush for the PC and the IF/ID register.
module control_unit #(
    parameter int unsigned BR_BUBBLES = 3,
    parameter int unsigned SB_DEPTH   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_opcode,
    input  logic [2:0]  id_src1,
    input  logic [2:0]  id_src2,
    input  logic [2:0]  id_dest,
    input  logic        m_branch_en,
    output logic        cu_reg_load,
    output logic        cu_alu_sel_b,
    output logic [10:0] cu_alu_opcode,
    output logic        cu_dm_wea,
    output logic        cu_reg_data_loc,
    output logic [1:0]  cu_branch,
    output logic        cu_stall,
    output logic        cu_flush,
    output logic        halted
);

    localparam int unsigned CNT_W = (BR_BUBBLES > 1) ? $clog2(BR_BUBBLES) : 1;

    // Opcode map
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SLA  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_LI   = 4'h9;
    localparam logic [3:0] OP_LW   = 4'hA;
    localparam logic [3:0] OP_SW   = 4'hB;
    localparam logic [3:0] OP_BIZ  = 4'hC;
    localparam logic [3:0] OP_BNZ  = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    // One-hot ALU operation bits
    localparam logic [10:0] ALU_ADD   = 11'h001;
    localparam logic [10:0] ALU_SUB   = 11'h002;
    localparam logic [10:0] ALU_AND   = 11'h004;
    localparam logic [10:0] ALU_OR    = 11'h008;
    localparam logic [10:0] ALU_XOR   = 11'h010;
    localparam logic [10:0] ALU_NOT   = 11'h020;
    localparam logic [10:0] ALU_SLA   = 11'h040;
    localparam logic [10:0] ALU_SRA   = 11'h080;
    localparam logic [10:0] ALU_PASSB = 11'h100;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_BR_WAIT = 2'd1,
        S_HALTED  = 2'd2
    } state_t;

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic [SB_DEPTH-1:0]        sb_valid;
    logic [SB_DEPTH-1:0][2:0]   sb_dest;

    // Decoded control word of the ID instruction, before bubble insertion
    logic        dec_reg_load;
    logic        dec_alu_sel_b;
    logic [10:0] dec_alu_opcode;
    logic        dec_dm_wea;
    logic        dec_reg_data_loc;
    logic [1:0]  dec_branch;
    logic        dec_is_branch;
    logic        dec_is_halt;
    logic        use_src1;
    logic        use_src2;

    logic        hazard;
    logic        issue;

    // Opcode decode into control word and source-usage flags
    always_comb begin
        dec_reg_load     = 1'b0;
        dec_alu_sel_b    = 1'b0;
        dec_alu_opcode   = '0;
        dec_dm_wea       = 1'b0;
        dec_reg_data_loc = 1'b0;
        dec_branch       = 2'b00;
        dec_is_branch    = 1'b0;
        dec_is_halt      = 1'b0;
        use_src1         = 1'b0;
        use_src2         = 1'b0;
        unique case (id_opcode)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLA, OP_SRA: begin
                dec_reg_load = 1'b1;
                use_src1     = 1'b1;
                use_src2     = 1'b1;
                unique case (id_opcode)
                    OP_ADD:  dec_alu_opcode = ALU_ADD;
                    OP_SUB:  dec_alu_opcode = ALU_SUB;
                    OP_AND:  dec_alu_opcode = ALU_AND;
                    OP_OR:   dec_alu_opcode = ALU_OR;
                    OP_XOR:  dec_alu_opcode = ALU_XOR;
                    OP_SLA:  dec_alu_opcode = ALU_SLA;
                    default: dec_alu_opcode = ALU_SRA;
                endcase
            end
            OP_NOT: begin
                dec_reg_load   = 1'b1;
                dec_alu_opcode = ALU_NOT;
                use_src1       = 1'b1;
            end
            OP_LI: begin
                dec_reg_load   = 1'b1;
                dec_alu_sel_b  = 1'b1;
                dec_alu_opcode = ALU_PASSB;
            end
            OP_LW: begin
                dec_reg_load     = 1'b1;
                dec_alu_sel_b    = 1'b1;
                dec_alu_opcode   = ALU_ADD;
                dec_reg_data_loc = 1'b1;
                use_src1         = 1'b1;
            end
            OP_SW: begin
                dec_alu_sel_b  = 1'b1;
                dec_alu_opcode = ALU_ADD;
                dec_dm_wea     = 1'b1;
                use_src1       = 1'b1;
                use_src2       = 1'b1;
            end
            OP_BIZ, OP_BNZ: begin
                dec_alu_opcode = ALU_SUB;
                dec_branch     = (id_opcode == OP_BIZ) ? 2'b01 : 2'b10;
                dec_is_branch  = 1'b1;
                use_src1       = 1'b1;
            end
            OP_JMP: begin
                dec_branch    = 2'b11;
                dec_is_branch = 1'b1;
            end
            OP_HALT: dec_is_halt = 1'b1;
            default: ;
        endcase
    end

    // RAW check of used sources against every valid in-flight destination
    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i] &&
                ((use_src1 && (sb_dest[i] == id_src1)) ||
                 (use_src2 && (sb_dest[i] == id_src2)))) begin
                hazard = 1'b1;
            end
        end
    end

    assign issue = (state == S_RUN) && !hazard;

    // Bubble insertion and pipeline hold/squash control
    always_comb begin
        cu_reg_load     = 1'b0;
        cu_alu_sel_b    = 1'b0;
        cu_alu_opcode   = '0;
        cu_dm_wea       = 1'b0;
        cu_reg_data_loc = 1'b0;
        cu_branch       = 2'b00;
        cu_stall        = 1'b0;
        cu_flush        = 1'b0;
        if (issue) begin
            cu_reg_load     = dec_reg_load;
            cu_alu_sel_b    = dec_alu_sel_b;
            cu_alu_opcode   = dec_alu_opcode;
            cu_dm_wea       = dec_dm_wea;
            cu_reg_data_loc = dec_reg_data_loc;
            cu_branch       = dec_branch;
            // The branch issue cycle already holds the fetch of its successor
            cu_stall        = dec_is_branch;
        end else begin
            cu_stall = 1'b1;
        end
        cu_flush = (state == S_BR_WAIT) && m_branch_en;
    end

    // FSM, branch bubble counter, halted flag and destination scoreboard
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_RUN;
            cnt      <= '0;
            sb_valid <= '0;
            sb_dest  <= '0;
            halted   <= 1'b0;
        end else begin
            for (int unsigned i = SB_DEPTH - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_dest[i]  <= sb_dest[i-1];
            end
            sb_valid[0] <= issue && dec_reg_load;
            sb_dest[0]  <= id_dest;

            unique case (state)
                S_RUN: begin
                    if (issue && dec_is_branch) begin
                        state <= S_BR_WAIT;
                        cnt   <= CNT_W'(BR_BUBBLES - 1);
                    end else if (issue && dec_is_halt) begin
                        state  <= S_HALTED;
                        halted <= 1'b1;
                    end
                end
                S_BR_WAIT: begin
                    if (cnt == '0) begin
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HALTED: halted <= 1'b1;
                default:  state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: cycle-by-cycle vector table for control_unit. Each row
// drives ID inputs for one cycle; its expected outputs go through a queue and
// are compared mid-cycle. A hand-written JMP sequence ends the run.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [3:0]  id_opcode;
    logic [2:0]  id_src1;
    logic [2:0]  id_src2;
    logic [2:0]  id_dest;
    logic        m_branch_en;
    logic        cu_reg_load;
    logic        cu_alu_sel_b;
    logic [10:0] cu_alu_opcode;
    logic        cu_dm_wea;
    logic        cu_reg_data_loc;
    logic [1:0]  cu_branch;
    logic        cu_stall;
    logic        cu_flush;
    logic        halted;

    int n_chk;
    int n_fail;

    control_unit #(.BR_BUBBLES(3), .SB_DEPTH(3)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_opcode       (id_opcode),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_dest         (id_dest),
        .m_branch_en     (m_branch_en),
        .cu_reg_load     (cu_reg_load),
        .cu_alu_sel_b    (cu_alu_sel_b),
        .cu_alu_opcode   (cu_alu_opcode),
        .cu_dm_wea       (cu_dm_wea),
        .cu_reg_data_loc (cu_reg_data_loc),
        .cu_branch       (cu_branch),
        .cu_stall        (cu_stall),
        .cu_flush        (cu_flush),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word {reg_load, sel_b, alu[10:0], dm_wea, data_loc, branch[1:0]}
    localparam logic [16:0] C_NOP = 17'h0;
    localparam logic [16:0] C_ADD = {1'b1, 1'b0, 11'h001, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_SUB = {1'b1, 1'b0, 11'h002, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_AND = {1'b1, 1'b0, 11'h004, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_OR  = {1'b1, 1'b0, 11'h008, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_XOR = {1'b1, 1'b0, 11'h010, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_NOT = {1'b1, 1'b0, 11'h020, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_SLA = {1'b1, 1'b0, 11'h040, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_SRA = {1'b1, 1'b0, 11'h080, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_LI  = {1'b1, 1'b1, 11'h100, 1'b0, 1'b0, 2'b00};
    localparam logic [16:0] C_LW  = {1'b1, 1'b1, 11'h001, 1'b0, 1'b1, 2'b00};
    localparam logic [16:0] C_SW  = {1'b0, 1'b1, 11'h001, 1'b1, 1'b0, 2'b00};
    localparam logic [16:0] C_BIZ = {1'b0, 1'b0, 11'h002, 1'b0, 1'b0, 2'b01};
    localparam logic [16:0] C_BNZ = {1'b0, 1'b0, 11'h002, 1'b0, 1'b0, 2'b10};
    localparam logic [16:0] C_JMP = {1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 2'b11};

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  s1;
        logic [2:0]  s2;
        logic [2:0]  d;
        logic        mb;
        logic        rn;
        logic [16:0] ctrl;
        logic        st;
        logic        fl;
        logic        h;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    function automatic vec_t v(input logic [3:0] op, input logic [2:0] s1, input logic [2:0] s2,
                               input logic [2:0] d, input logic mb, input logic rn,
                               input logic [16:0] ctrl, input logic st, input logic fl,
                               input logic h);
        vec_t r;
        r.op = op; r.s1 = s1; r.s2 = s2; r.d = d; r.mb = mb; r.rn = rn;
        r.ctrl = ctrl; r.st = st; r.fl = fl; r.h = h;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic drive(input vec_t r);
        id_opcode   = r.op;
        id_src1     = r.s1;
        id_src2     = r.s2;
        id_dest     = r.d;
        m_branch_en = r.mb;
        rst_n       = r.rn;
    endtask

    logic [16:0] ctrl_act;
    assign ctrl_act = {cu_reg_load, cu_alu_sel_b, cu_alu_opcode, cu_dm_wea,
                       cu_reg_data_loc, cu_branch};

    initial begin
        vec_t e;
        int   stall_cycles;
        n_chk  = 0;
        n_fail = 0;

        //          op    s1 s2 d  mb rn  ctrl   st fl h
        // reset state, then every non-branch opcode with no hazard
        tbl.push_back(v(4'h0, 1, 2, 7, 0, 1, C_NOP, 0, 0, 0));
        tbl.push_back(v(4'h1, 1, 2, 7, 0, 1, C_ADD, 0, 0, 0));
        tbl.push_back(v(4'h2, 1, 2, 7, 0, 1, C_SUB, 0, 0, 0));
        tbl.push_back(v(4'h3, 1, 2, 7, 0, 1, C_AND, 0, 0, 0));
        tbl.push_back(v(4'h4, 1, 2, 7, 0, 1, C_OR,  0, 0, 0));
        tbl.push_back(v(4'h5, 1, 2, 7, 0, 1, C_XOR, 0, 0, 0));
        tbl.push_back(v(4'h6, 1, 2, 7, 0, 1, C_NOT, 0, 0, 0));
        tbl.push_back(v(4'h7, 1, 2, 7, 0, 1, C_SLA, 0, 0, 0));
        tbl.push_back(v(4'h8, 1, 2, 7, 0, 1, C_SRA, 0, 0, 0));
        tbl.push_back(v(4'h9, 1, 2, 7, 0, 1, C_LI,  0, 0, 0));
        tbl.push_back(v(4'hA, 1, 2, 7, 0, 1, C_LW,  0, 0, 0));
        tbl.push_back(v(4'hB, 1, 2, 7, 0, 1, C_SW,  0, 0, 0));
        // ADD r1,r2,r3 then ADD r4,r1,r5: three bubbles with stall
        tbl.push_back(v(4'h1, 2, 3, 1, 0, 1, C_ADD, 0, 0, 0));
        tbl.push_back(v(4'h1, 1, 5, 4, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 1, 5, 4, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 1, 5, 4, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 1, 5, 4, 0, 1, C_ADD, 0, 0, 0));
        // LW r2 then SW reading r2 as src2
        tbl.push_back(v(4'hA, 3, 0, 2, 0, 1, C_LW,  0, 0, 0));
        tbl.push_back(v(4'hB, 5, 2, 0, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'hB, 5, 2, 0, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'hB, 5, 2, 0, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'hB, 5, 2, 0, 0, 1, C_SW,  0, 0, 0));
        // register 0 is tracked like any other
        tbl.push_back(v(4'h9, 3, 3, 0, 0, 1, C_LI,  0, 0, 0));
        tbl.push_back(v(4'h1, 0, 5, 6, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 0, 5, 6, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 0, 5, 6, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 0, 5, 6, 0, 1, C_ADD, 0, 0, 0));
        // NOT ignores src2 even when it matches a pending dest
        tbl.push_back(v(4'h1, 4, 5, 3, 0, 1, C_ADD, 0, 0, 0));
        tbl.push_back(v(4'h6, 2, 3, 5, 0, 1, C_NOT, 0, 0, 0));
        // BIZ (src2 unused), branch taken on the third bubble
        tbl.push_back(v(4'hC, 1, 5, 0, 0, 1, C_BIZ, 1, 0, 0));
        tbl.push_back(v(4'h1, 1, 2, 7, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 1, 2, 7, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 1, 2, 7, 1, 1, C_NOP, 1, 1, 0));
        tbl.push_back(v(4'h1, 1, 2, 7, 1, 1, C_ADD, 0, 0, 0));
        // JMP reads no sources; held instruction issues after three bubbles
        tbl.push_back(v(4'hE, 7, 7, 0, 0, 1, C_JMP, 1, 0, 0));
        tbl.push_back(v(4'h2, 1, 3, 2, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h2, 1, 3, 2, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h2, 1, 3, 2, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h2, 1, 3, 2, 0, 1, C_SUB, 0, 0, 0));
        // a hazarded branch stalls in RUN before entering the branch window
        tbl.push_back(v(4'h9, 0, 0, 6, 0, 1, C_LI,  0, 0, 0));
        tbl.push_back(v(4'hD, 6, 0, 0, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'hD, 6, 0, 0, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'hD, 6, 0, 0, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'hD, 6, 0, 0, 0, 1, C_BNZ, 1, 0, 0));
        tbl.push_back(v(4'h1, 4, 5, 1, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 4, 5, 1, 0, 1, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 4, 5, 1, 0, 1, C_NOP, 1, 0, 0));
        // fill scoreboard, branch, reset inside the branch window
        tbl.push_back(v(4'h1, 4, 5, 1, 0, 1, C_ADD, 0, 0, 0));
        tbl.push_back(v(4'h1, 4, 5, 2, 0, 1, C_ADD, 0, 0, 0));
        tbl.push_back(v(4'h1, 4, 5, 3, 0, 1, C_ADD, 0, 0, 0));
        tbl.push_back(v(4'hD, 6, 0, 0, 0, 1, C_BNZ, 1, 0, 0));
        tbl.push_back(v(4'h1, 3, 2, 4, 0, 0, C_NOP, 1, 0, 0));
        tbl.push_back(v(4'h1, 3, 2, 4, 0, 1, C_ADD, 0, 0, 0));
        // HALT, sticky halted, m_branch_en ignored, reset recovers
        tbl.push_back(v(4'hF, 1, 2, 0, 0, 1, C_NOP, 0, 0, 0));
        tbl.push_back(v(4'h1, 1, 2, 5, 0, 1, C_NOP, 1, 0, 1));
        tbl.push_back(v(4'h1, 1, 2, 5, 1, 1, C_NOP, 1, 0, 1));
        tbl.push_back(v(4'h1, 1, 2, 5, 0, 0, C_NOP, 1, 0, 1));
        tbl.push_back(v(4'h1, 1, 2, 5, 0, 1, C_ADD, 0, 0, 0));

        drive(v(4'h0, 0, 0, 0, 0, 0, C_NOP, 0, 0, 0));
        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("row%0d ctrl", i), 32'(ctrl_act), 32'(e.ctrl));
            chk($sformatf("row%0d stall", i), 32'(cu_stall), 32'(e.st));
            chk($sformatf("row%0d flush", i), 32'(cu_flush), 32'(e.fl));
            chk($sformatf("row%0d halted", i), 32'(halted), 32'(e.h));
        end

        // JMP: stall stays high for the issue cycle plus three bubbles
        @(posedge clk);
        #1;
        id_opcode = 4'hE; id_src1 = 0; id_src2 = 0; id_dest = 0; m_branch_en = 0; rst_n = 1;
        @(negedge clk);
        chk("jmp branch", 32'(cu_branch), 32'(2'b11));
        stall_cycles = 0;
        while (cu_stall && stall_cycles < 10) begin
            stall_cycles++;
            @(posedge clk);
            #1;
            id_opcode = 4'h0;
            @(negedge clk);
        end
        chk("jmp stall cycles", 32'(stall_cycles), 32'd4);
        chk("jmp after ctrl", 32'(ctrl_act), 32'(C_NOP));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
